// File: rtl/fp_pkg.sv
// Shared fixed-point types and the round-half-up / saturate narrowing helper.
package fp_pkg;

  localparam int unsigned FP_IBITS = 12;
  localparam int unsigned FP_FBITS = 20;
  localparam int unsigned W        = FP_IBITS + FP_FBITS;

  typedef logic signed [W-1:0] single_t;
  typedef logic signed [2*W:0] wide_t;

  typedef enum logic [1:0] {
    MODE_FMA  = 2'b00,
    MODE_FMS  = 2'b01,
    MODE_NFMS = 2'b10,
    MODE_MUL  = 2'b11
  } mode_e;

  localparam wide_t SINGLE_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam wide_t SINGLE_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  // Returns {sat, value}; sat set only when the clamp altered the rounded value.
  function automatic logic [W:0] fp_round_sat(input wide_t s, input int unsigned fb);
    wide_t t;
    t = (s + (wide_t'(1) <<< (fb - 1))) >>> fb;
    if (t > SINGLE_MAX)
      return {1'b1, SINGLE_MAX[W-1:0]};
    else if (t < SINGLE_MIN)
      return {1'b1, SINGLE_MIN[W-1:0]};
    else
      return {1'b0, t[W-1:0]};
  endfunction

endpackage

// File: rtl/fp_round_sat_stage.sv
// Registered narrowing stage: rounds a wide accumulator to single width with saturation.
module fp_round_sat_stage
  import fp_pkg::*;
#(
  parameter int unsigned fbits   = FP_FBITS,
  parameter int unsigned id_bits = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  wide_t              acc_in,
  input  logic [id_bits-1:0] id_in,
  input  logic               valid_in,
  output single_t            r,
  output logic               sat,
  output logic [id_bits-1:0] id_out,
  output logic               valid_out
);

  single_t            r_q, r_d;
  logic               sat_q, sat_d;
  logic [id_bits-1:0] id_q, id_d;
  logic               valid_q, valid_d;
  logic [W:0]         rs;

  always_comb begin
    rs      = fp_round_sat(acc_in, fbits);
    r_d     = r_q;
    sat_d   = sat_q;
    id_d    = id_q;
    valid_d = valid_q;
    if (enable) begin
      r_d     = rs[W-1:0];
      sat_d   = rs[W];
      id_d    = id_in;
      valid_d = valid_in;
    end
    if (reset || clear) valid_d = 1'b0;
    if (reset) sat_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    r_q     <= r_d;
    sat_q   <= sat_d;
    id_q    <= id_d;
    valid_q <= valid_d;
  end

  assign r         = r_q;
  assign sat       = sat_q;
  assign id_out    = id_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fp_fma_sat.sv
// Pipelined fixed-point FMA with mode select, round-half-up narrowing and saturation.
module fp_fma_sat
  import fp_pkg::*;
#(
  parameter int unsigned ibits   = FP_IBITS,
  parameter int unsigned fbits   = FP_FBITS,
  parameter int unsigned id_bits = 8,
  parameter int unsigned latency = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [ibits+fbits-1:0]   a,
  input  logic [ibits+fbits-1:0]   b,
  input  logic [ibits+fbits-1:0]   c,
  input  logic [1:0]               mode,
  input  logic [id_bits-1:0]       iid,
  input  logic                     ivalid,
  output logic                     iready,
  output logic [ibits+fbits-1:0]   r,
  output logic                     sat,
  output logic [id_bits-1:0]       oid,
  output logic                     ovalid,
  input  logic                     oready
);

  localparam int unsigned NS = latency - 1;

  typedef struct packed {
    wide_t              acc;
    logic [id_bits-1:0] id;
    logic               valid;
  } slot_t;

  slot_t      slot_q [NS];
  slot_t      slot_d [NS];
  single_t    c0_q, c0_d;
  mode_e      mode0_q, mode0_d;
  logic       advance, accept;
  logic [2*W-1:0] p2;
  wide_t      c_al, sum;
  slot_t      last;

  assign advance = !ovalid || oready;
  assign iready  = advance && !flush;
  assign accept  = ivalid && iready;

  always_comb begin
    p2   = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    c_al = {{(W+1-fbits){c0_q[W-1]}}, c0_q, {fbits{1'b0}}};
    unique case (mode0_q)
      MODE_FMA:  sum = slot_q[0].acc + c_al;
      MODE_FMS:  sum = slot_q[0].acc - c_al;
      MODE_NFMS: sum = c_al - slot_q[0].acc;
      default:   sum = slot_q[0].acc;
    endcase
  end

  always_comb begin
    slot_d  = slot_q;
    c0_d    = c0_q;
    mode0_d = mode0_q;
    if (advance) begin
      slot_d[0] = '{acc: {p2[2*W-1], p2}, id: iid, valid: accept};
      c0_d      = c;
      mode0_d   = mode_e'(mode);
      for (int unsigned i = 1; i < NS; i++) begin
        if (i == 1) slot_d[i] = '{acc: sum, id: slot_q[0].id, valid: slot_q[0].valid};
        else        slot_d[i] = slot_q[i-1];
      end
    end
    if (reset || flush)
      for (int unsigned i = 0; i < NS; i++) slot_d[i].valid = 1'b0;
  end

  // Rounding sits in the final slot; delay slots are placed between add and round,
  // which is externally identical and lets latency=2 merge add+round naturally.
  always_comb begin
    if (NS == 1) last = '{acc: sum, id: slot_q[0].id, valid: slot_q[0].valid};
    else         last = slot_q[NS-1];
  end

  always_ff @(posedge clock) begin
    slot_q  <= slot_d;
    c0_q    <= c0_d;
    mode0_q <= mode0_d;
  end

  fp_round_sat_stage #(
    .fbits  (fbits),
    .id_bits(id_bits)
  ) u_round_sat (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .enable   (advance),
    .acc_in   (last.acc),
    .id_in    (last.id),
    .valid_in (last.valid),
    .r        (r),
    .sat      (sat),
    .id_out   (oid),
    .valid_out(ovalid)
  );

endmodule

// File: tb/tb_fp_fma_sat.sv
// Directed and randomised checks of fp_fma_sat (Q12.20, latency 4) against a longint model.
module tb_fp_fma_sat;

  logic        clock = 1'b0;
  logic        reset, flush, ivalid, oready;
  logic [31:0] a, b, c;
  logic [1:0]  mode;
  logic [7:0]  iid;
  logic        iready, sat, ovalid;
  logic [31:0] r;
  logic [7:0]  oid;

  typedef struct {
    logic [31:0] r;
    logic        sat;
    logic [7:0]  id;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc_n = 0, n_acc = 0, n_out = 0, acc_cyc = 0, out_cyc = 0;
  logic acc_f;

  always #5 clock = ~clock;

  fp_fma_sat #(.ibits(12), .fbits(20), .id_bits(8), .latency(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .a(a), .b(b), .c(c), .mode(mode),
    .iid(iid), .ivalid(ivalid), .iready(iready), .r(r), .sat(sat), .oid(oid),
    .ovalid(ovalid), .oready(oready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] ma, mb, mc, input logic [1:0] mm);
    longint p, cs, s, t;
    p  = longint'($signed(ma)) * longint'($signed(mb));
    cs = longint'($signed(mc)) <<< 20;
    case (mm)
      2'b00:   s = p + cs;
      2'b01:   s = p - cs;
      2'b10:   s = cs - p;
      default: s = p;
    endcase
    t = (s + 64'sd524288) >>> 20;
    if (t > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (t < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, t[31:0]};
  endfunction

  // One clock cycle: drive at negedge, sample handshakes 1 ns later.
  task automatic cyc(input logic iv, input logic [31:0] ta, tb, tc, input logic [1:0] tm,
                     input logic [7:0] tid, input logic ordy, input logic fl,
                     input logic [31:0] er, input logic es);
    exp_t e;
    @(negedge clock);
    ivalid = iv; a = ta; b = tb; c = tc; mode = tm; iid = tid; oready = ordy; flush = fl;
    #1;
    cyc_n++;
    if (ovalid && oready) begin
      if (sb.size() == 0) check("spurious_out", {56'd0, oid}, 64'hFFFF);
      else begin
        e = sb.pop_front();
        check("r", r, e.r);
        check("sat", sat, e.sat);
        check("oid", oid, e.id);
      end
      n_out++;
      out_cyc = cyc_n;
    end
    acc_f = ivalid && iready;
    if (acc_f) begin
      sb.push_back('{r: er, sat: es, id: tid});
      n_acc++;
      acc_cyc = cyc_n;
    end
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 8'd0, ordy, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic one(input string tag, input logic [31:0] ta, tb, tc, input logic [1:0] tm,
                     input logic [7:0] tid, input logic [31:0] er, input logic es);
    int k;
    cyc(1'b1, ta, tb, tc, tm, tid, 1'b1, 1'b0, er, es);
    check({tag, "_acc"}, acc_f, 1'b1);
    k = n_out;
    for (int i = 0; i < 12 && n_out == k; i++) idle(1'b1);
    check({tag, "_nout"}, n_out, k + 1);
    check({tag, "_lat"}, out_cyc - acc_cyc, 4);
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] ra, rb, rc, r0;
    logic [7:0]  o0, nid;
    logic [1:0]  rm;
    int n0, f, first, target;

    reset = 1'b1; flush = 1'b0; ivalid = 1'b0; oready = 1'b1;
    a = '0; b = '0; c = '0; mode = '0; iid = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_ovalid", ovalid, 1'b0);
    check("rst_iready", iready, 1'b1);
    check("rst_sat", sat, 1'b0);

    one("fma",   32'h0018_0000, 32'h0020_0000, 32'h0004_0000, 2'b00, 8'h01, 32'h0034_0000, 1'b0);
    one("fms",   32'h0018_0000, 32'h0020_0000, 32'h0004_0000, 2'b01, 8'h02, 32'h002C_0000, 1'b0);
    one("nfms",  32'h0018_0000, 32'h0020_0000, 32'h0004_0000, 2'b10, 8'h03, 32'hFFD4_0000, 1'b0);
    one("mul_c", 32'h0018_0000, 32'h0020_0000, 32'h7FFF_FFFF, 2'b11, 8'h04, 32'h0030_0000, 1'b0);
    one("satp",  32'h7FF0_0000, 32'h7FF0_0000, 32'h0000_0000, 2'b11, 8'h05, 32'h7FFF_FFFF, 1'b1);
    one("satn",  32'h7FF0_0000, 32'h8010_0000, 32'h0000_0000, 2'b11, 8'h06, 32'h8000_0000, 1'b1);
    one("rndup", 32'h0000_0001, 32'h0008_0000, 32'h0000_0000, 2'b00, 8'h07, 32'h0000_0001, 1'b0);
    one("rndn",  32'h0000_0001, 32'hFFF8_0000, 32'h0000_0000, 2'b00, 8'h08, 32'h0000_0000, 1'b0);
    one("negmx", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2'b10, 8'h09, 32'h8000_0000, 1'b1);

    // Backpressure: oready low for 20 cycles with ivalid held high.
    nid = 8'h10; n0 = n_acc; r0 = '0; o0 = '0;
    for (int i = 0; i < 20; i++) begin
      rb = 32'(i) <<< 20;
      m = model(32'h0010_0000, rb, 32'h0001_0000, 2'b00);
      cyc(1'b1, 32'h0010_0000, rb, 32'h0001_0000, 2'b00, nid, 1'b0, 1'b0, m[31:0], m[32]);
      if (acc_f) nid++;
      if (i == 10) begin r0 = r; o0 = oid; check("bp_ovalid", ovalid, 1'b1); end
    end
    check("bp_accepts", n_acc - n0, 4);
    check("bp_iready", iready, 1'b0);
    check("bp_r_stable", r, r0);
    check("bp_oid_stable", oid, o0);
    f = n_out; first = -1;
    for (int i = 0; i < 10 && n_out < f + 4; i++) begin
      idle(1'b1);
      if (first < 0 && n_out > f) first = out_cyc;
    end
    check("bp_drained", n_out - f, 4);
    check("bp_back2back", out_cyc - first, 3);

    // Flush with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h0010_0000, 32'h0010_0000, 32'h0, 2'b11, 8'h20 + 8'(i), 1'b1, 1'b0,
          32'h0010_0000, 1'b0);
    end
    cyc(1'b1, 32'h0010_0000, 32'h0010_0000, 32'h0, 2'b11, 8'h23, 1'b1, 1'b1, 32'h0010_0000, 1'b0);
    check("flush_iready", iready, 1'b0);
    sb.delete();
    cyc(1'b1, 32'h0020_0000, 32'h0020_0000, 32'h0, 2'b11, 8'h30, 1'b1, 1'b0, 32'h0040_0000, 1'b0);
    check("flush_ovalid", ovalid, 1'b0);
    check("post_flush_acc", acc_f, 1'b1);
    f = n_out;
    for (int i = 0; i < 12 && n_out == f; i++) idle(1'b1);
    check("post_flush_nout", n_out, f + 1);
    check("post_flush_lat", out_cyc - acc_cyc, 4);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("flush_no_extra", n_out, f + 1);

    // Random traffic with random backpressure.
    nid = 8'h40;
    target = n_acc + 10000;
    for (int i = 0; i < 60000 && n_acc < target; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom; rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) ra = $signed(ra) >>> $urandom_range(4, 24);
      if ($urandom_range(0, 1) == 1) rb = $signed(rb) >>> $urandom_range(4, 24);
      if ($urandom_range(0, 1) == 1) rc = $signed(rc) >>> $urandom_range(0, 16);
      m = model(ra, rb, rc, rm);
      cyc($urandom_range(0, 3) != 0, ra, rb, rc, rm, nid, $urandom_range(0, 3) != 0, 1'b0,
          m[31:0], m[32]);
      if (acc_f) nid++;
    end
    check("rand_count", n_acc, target);
    for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1'b1);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_fma_sat.md
Name: fp_fma_sat

Overview:
Pipelined fixed-point fused multiply-add with per-transaction operation mode, round-to-nearest narrowing and saturation back to single-width Q(ibits.fbits). It is the next-generation FMA for the RANSAC datapath (model fitting, residual evaluation). Unlike the existing double-width-output FMA, results come back in operand format, ready for chaining. It has full valid/ready backpressure, a flush input and a saturation flag.

Parameters:
ibits, 12, integer bits of single-width operand (incl. sign)
fbits, 20, fractional bits; must be >= 1
id_bits, 8, transaction tag width
latency, 4, cycles from accept to ovalid; legal range 2..16

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
flush  in  1  synchronous; drops all in-flight transactions
a  in  W=ibits+fbits  signed multiplicand, Q(ibits.fbits)
b  in  W  signed multiplier, Q(ibits.fbits)
c  in  W  signed addend, Q(ibits.fbits)
mode  in  2  00 a*b+c; 01 a*b-c; 10 c-a*b; 11 a*b (c ignored)
iid  in  id_bits  tag, returned unchanged
ivalid  in  1  input valid
iready  out  1  input ready
r  out  W  rounded, saturated result
sat  out  1  r was clamped
oid  out  id_bits  tag of r
ovalid  out  1  output valid
oready  in  1  consumer ready

Behaviour:
- Accept when ivalid && iready. Output transfer when ovalid && oready.
- Pipeline is latency slots; the last slot drives r/sat/oid/ovalid directly from registers.
- advance = !ovalid || oready. All slots shift together when advance is high; otherwise all hold.
- iready = advance (combinational from oready and ovalid). This path is intentional.
- An accepted transaction reaches ovalid exactly latency cycles later if advance stays high. Bubbles are not collapsed.
- Throughput: one transaction per cycle while oready is held high.
- Arithmetic:
  - p = signed(a)*signed(b), 2W bits, Q(2ibits.2fbits).
  - c is sign-extended and shifted left by fbits to align.
  - s = ±p ±c per mode, computed at 2W+1 bits; no intermediate overflow is possible.
  - Round half up: s + 2^(fbits-1), then arithmetic shift right by fbits.
  - Clamp to [-2^(W-1), 2^(W-1)-1]. sat = 1 iff clamping changed the value.
  - Negating p in modes 10 is exact at 2W+1 bits, including the most-negative product.
- Stage split: multiply in slot 0; add/subtract in slot 1; round/saturate in slot 2 (or merged into slot 1 when latency = 2); remaining slots are delay.
- Reset: all slot valids 0, ovalid 0, sat 0, iready 1 from the first cycle after reset deasserts. Data registers are not reset. Reset mid-operation discards in-flight work silently.
- flush: same effect as reset on valids and ovalid. An input presented in the flush cycle is not accepted (iready forced 0 that cycle). reset has priority over flush.
- While ovalid && !oready: r, sat and oid are held stable.
- Ordering: results leave in acceptance order. No drop, no duplication.

Decomposition:
- Shared package fp_pkg (extend the existing one if present):
  - localparam W and the single_t, wide_t (2W+1) and mode_e types.
  - function fp_round_sat(wide_t, fbits) returning {sat, single_t}.
- One sub-module: fp_round_sat_stage. It is a registered narrowing stage reusable by other fixed-point blocks.
- Slot storage is a parameterised array of a packed struct {wide_t acc; id; valid}.

Test Plan (ibits=12, fbits=20, latency=4):
- a=0x0018_0000 (1.5), b=0x0020_0000 (2.0), c=0x0004_0000 (0.25), mode 00, oready=1 -> r=0x0034_0000 (3.25), sat=0, ovalid 4 cycles after accept; mode 01 -> 0x002C_0000 (2.75); mode 10 -> 0xFFD4_0000 (-2.75).
- a=b=0x7FF0_0000, mode 11 -> r=0x7FFF_FFFF, sat=1. a=0x7FF0_0000, b=0x8010_0000, mode 11 -> r=0x8000_0000, sat=1.
- Rounding: a=0x0000_0001, b=0x0008_0000 (0.5), c=0, mode 00 -> r=0x0000_0001. Same with b=0xFFF8_0000 (-0.5) -> r=0x0000_0000.
- Backpressure: ivalid=1 continuously with incrementing iid, oready=0 for 20 cycles -> exactly 4 transactions accepted, then iready=0 and r/oid stable. oready=1 afterwards -> iids delivered in order, no gaps or duplicates, one per cycle.
- flush with 3 transactions in flight -> ovalid=0 next cycle, none of those iids ever emerge. A new accept 1 cycle later emerges after 4 cycles.
- Random mode/operands, 10k transactions, random oready -> every r/sat matches the reference model, with the same ordering check as above.
